// File: rtl/seq_mult_iter.sv
// ---------------------------------------------------------------------------
// seq_mult_iter
//   Iterative shift-add multiplier with valid/ready handshakes on both sides.
//   One partial-product add per BUSY cycle. Exits early once the remaining
//   multiplier bits are all zero.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid and ready are both high. in_ready/out_valid depend on the
//   state register only. There is no combinational path from in_valid or
//   out_ready to any output.
//
//   Optional feature: define SEQ_MULT_SIGNED_EN for two's-complement
//   operands and product. It is undefined by default, which gives an
//   unsigned multiplier.
//
// Parameters:
//   W            operand width (2..32)
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair present
//   in_ready     high in IDLE, block can accept a pair
//   a, b         multiplicand / multiplier (W bits)
//   out_valid    high in DONE, product present
//   out_ready    consumer accepts the product
//   p            product (2W bits)
//   busy         high in BUSY and DONE
//   o_dbg_state  FSM state (0 IDLE, 1 BUSY, 2 DONE) for observation
// ---------------------------------------------------------------------------
module seq_mult_iter #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy,
  output logic [1:0]     o_dbg_state
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_sum;
  logic [2*W-1:0] w_acc_fin;
  logic [W-1:0]   w_mplier_shr;
  logic [CW-1:0]  w_cnt_inc;
  logic           w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;

  // The magnitude of the most negative value, 2^(W-1), still fits in W
  // unsigned bits, so the negation needs no extra width.
  assign w_a_mag = a[W-1] ? (~a + W'(1)) : a;
  assign w_b_mag = b[W-1] ? (~b + W'(1)) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= a[W-1] ^ b[W-1];
    end
  end

  // Sign fix-up is folded into the exit edge, so latency matches unsigned.
  assign w_acc_fin = (w_last && r_neg) ? (~w_acc_sum + (2*W)'(1)) : w_acc_sum;
`else
  assign w_a_mag   = a;
  assign w_b_mag   = b;
  assign w_acc_fin = w_acc_sum;
`endif

  // One shift-add step. acc is 2W bits wide, so the sum cannot overflow.
  assign w_addend     = r_mplier[0] ? r_mcand : '0;
  assign w_acc_sum    = r_acc + w_addend;
  assign w_mplier_shr = r_mplier >> 1;
  assign w_cnt_inc    = r_cnt + CW'(1);
  // Early exit: no set multiplier bits remain, or all W bits are consumed.
  assign w_last       = (w_mplier_shr == '0) || (w_cnt_inc == CW'(W));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{W{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shr;
      r_acc    <= w_acc_fin;
      r_cnt    <= w_cnt_inc;
    end
  end

  // Outputs are decoded from registers only.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign p           = r_acc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_mult_iter.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_iter
//   Directed tests for seq_mult_iter at W=4, plus back-to-back traffic with
//   random stalls at W=8. The expected results follow the build's signedness
//   (SEQ_MULT_SIGNED_EN).
// ---------------------------------------------------------------------------
module tb_seq_mult_iter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- W=4 instance ----------------
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] p;
  logic       busy;
  logic [1:0] dbg_state;

  seq_mult_iter #(.W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- W=8 instance ----------------
  logic        iv8 = 1'b0;
  logic        ir8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8;
  logic        or8 = 1'b0;
  logic [15:0] p8;
  logic        busy8;
  logic [1:0]  dbg8;

  seq_mult_iter #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .p(p8),
    .busy(busy8), .o_dbg_state(dbg8)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // Reference product for the W=8 traffic.
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] ex, ey;
`ifdef SEQ_MULT_SIGNED_EN
    ex = {{8{x[7]}}, x};
    ey = {{8{y[7]}}, y};
`else
    ex = {8'b0, x};
    ey = {8'b0, y};
`endif
    return ex * ey;
  endfunction

  // Drives one operand pair on the W=4 DUT. It returns once out_valid is
  // seen, with the number of BUSY cycles. Call it at posedge+1 in IDLE.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb,
                        output int cyc, output logic [7:0] prod,
                        output logic tmo);
    in_valid = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      cyc++;
      @(posedge clk); #1;
    end
    tmo  = !out_valid;
    prod = p;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (p !== 8'h00) begin n_err++; $display("FAIL reset_p: got %h want 00", p); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: in_ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_vectors();
`ifdef SEQ_MULT_SIGNED_EN
    logic [3:0] va[4] = '{4'h8, 4'hD, 4'h7, 4'h0};
    logic [3:0] vb[4] = '{4'h8, 4'h5, 4'hF, 4'h8};
    logic [7:0] vp[4] = '{8'h40, 8'hF1, 8'hF9, 8'h00};
    int         vn[4] = '{4, 3, 1, 4};
    localparam int NV = 4;
`else
    logic [3:0] va[6] = '{4'hF, 4'h3, 4'h7, 4'h0, 4'h1, 4'h5};
    logic [3:0] vb[6] = '{4'hF, 4'h0, 4'h2, 4'hF, 4'h8, 4'h1};
    logic [7:0] vp[6] = '{8'hE1, 8'h00, 8'h0E, 8'h00, 8'h08, 8'h05};
    int         vn[6] = '{4, 1, 2, 4, 4, 1};
    localparam int NV = 6;
`endif
    int cyc;
    logic [7:0] prod;
    logic tmo;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      run_op(va[i], vb[i], cyc, prod, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL vec%0d_timeout: out_valid never rose", i); end
      n_cmp++; if (cyc != vn[i]) begin n_err++; $display("FAIL vec%0d_busy_cycles: got %0d want %0d", i, cyc, vn[i]); end
      n_cmp++; if (prod !== vp[i]) begin n_err++; $display("FAIL vec%0d_p: got %h want %h", i, prod, vp[i]); end
      @(posedge clk); #1;
      // out_valid lasts exactly one cycle and the block is ready again.
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d_handshake: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_hold();
`ifdef SEQ_MULT_SIGNED_EN
    logic [7:0] exp_p = 8'hDD;
`else
    logic [7:0] exp_p = 8'h2D;
`endif
    int cyc;
    logic [7:0] prod;
    logic tmo;
    out_ready = 1'b0;
    run_op(4'h9, 4'h5, cyc, prod, tmo);
    n_cmp++; if (tmo || cyc != 3) begin n_err++; $display("FAIL hold_busy_cycles: got %0d (timeout=%b) want 3", cyc, tmo); end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin in_valid = 1'b1; a = 4'h1; b = 4'h1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || p !== exp_p || in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_stable%0d: out_valid=%b p=%h in_ready=%b want 1/%h/0", i, out_valid, p, in_ready, exp_p);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1;
    // The pulse during the hold must not have started an operation.
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_ignored_pulse: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] prod;
    logic tmo;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 4'hF; b = 4'hF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_busy: busy=%b out_valid=%b want 1/0", busy, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 8'h00) begin
      n_err++; $display("FAIL mid_async_reset: in_ready=%b out_valid=%b busy=%b p=%h want 1/0/0/00", in_ready, out_valid, busy, p);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_no_stale: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    run_op(4'h2, 4'h3, cyc, prod, tmo);
    n_cmp++; if (tmo || cyc != 2) begin n_err++; $display("FAIL mid_after_cycles: got %0d (timeout=%b) want 2", cyc, tmo); end
    n_cmp++; if (prod !== 8'h06) begin n_err++; $display("FAIL mid_after_p: got %h want 06", prod); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    localparam int NP = 400;
    int acc_cnt = 0;
    int done_cnt = 0;
    int cycles = 0;
    logic [15:0] e;
    while (done_cnt < NP && cycles < 20000) begin
      iv8 = (acc_cnt < NP) && ($urandom_range(0, 3) != 0);
      a8  = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0:       b8 = 8'h00;
        1:       b8 = 8'hFF;
        2:       b8 = 8'h80;
        default: b8 = 8'($urandom_range(0, 255));
      endcase
      or8 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      // Inputs are stable from posedge+1, so the negedge view predicts the
      // transfers at the next rising edge.
      if (iv8 && ir8) begin
        exp_q.push_back(ref8(a8, b8));
        acc_cnt++;
      end
      if (ov8 && or8) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_dup: product %h with nothing outstanding", p8);
        end else begin
          e = exp_q.pop_front();
          if (p8 !== e) begin n_err++; $display("FAIL b2b_p #%0d: got %h want %h", done_cnt, p8, e); end
        end
        done_cnt++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    iv8 = 1'b0;
    or8 = 1'b0;
    n_cmp++; if (done_cnt != NP) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", done_cnt, NP); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_loss: %0d outstanding want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
